ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the companion of the keyboard scancode receiver.
- CPU writes a command byte over Avalon-MM slave s1, e.g. 0xED for set-LEDs or 0xFF for reset.
- Block drives the open-drain clock and data lines through the request-to-send sequence, shifts out data, parity and stop, then checks the device ACK.
- Raises ins_irq0_irq on completion or error; shares the kc/kd pads with the receiver.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_host_tx_if.sv | 19 +
 rtl/ps2_line_sync.sv | 57 +++++
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding, register map,
// status bit positions and frame length.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SHIFT,
      ST_ACK,
      ST_WAITIDLE
   } state_e;

   localparam logic ADDR_TXDATA = 1'b0;
   localparam logic ADDR_CTRL   = 1'b1;

   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;
   localparam int STAT_ACKERR = 2;
   localparam int STAT_TMO    = 3;
   localparam int STAT_OVR    = 4;
   localparam int STAT_IE     = 7;

   // data[7:0], odd parity, stop
   localparam int FRAME_LEN = 10;

endpackage

// File: rtl/ps2_host_tx_if.sv
// Avalon-MM slave s1 register port plus its level interrupt.
interface ps2_host_tx_if;
   logic       avs_s1_address;
   logic       avs_s1_read;
   logic       avs_s1_write;
   logic [7:0] avs_s1_writedata;
   logic [7:0] avs_s1_readdata;
   logic       ins_irq0_irq;

   modport master (
      output avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
      input  avs_s1_readdata, ins_irq0_irq
   );

   modport slave (
      input  avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
      output avs_s1_readdata, ins_irq0_irq
   );
endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pad synchronizer with kc falling-edge detect. Defining
// PS2_TX_GLITCH_FILTER_EN adds a 4-sample majority-free debounce on kc.
module ps2_line_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic kc_i,
   input  logic kd_i,
   output logic kc_o,
   output logic kd_o,
   output logic kc_fall_o
);
   logic [1:0] kc_sq, kd_sq;
   logic       kc_prev_q;
   logic       kc_f;

   // Lines idle high, so sync stages come out of reset high to avoid a false edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         kc_sq <= 2'b11;
         kd_sq <= 2'b11;
      end else begin
         kc_sq <= {kc_sq[0], kc_i};
         kd_sq <= {kd_sq[0], kd_i};
      end
   end

`ifdef PS2_TX_GLITCH_FILTER_EN
   logic [2:0] hist_q;
   logic       filt_q;
   logic [3:0] win;

   // Current sample plus the last three: the output follows on the 4th equal sample.
   assign win  = {hist_q, kc_sq[1]};
   assign kc_f = (&win) ? 1'b1 : ((~|win) ? 1'b0 : filt_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hist_q <= 3'b111;
         filt_q <= 1'b1;
      end else begin
         hist_q <= {hist_q[1:0], kc_sq[1]};
         filt_q <= kc_f;
      end
   end
`else
   assign kc_f = kc_sq[1];
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) kc_prev_q <= 1'b1;
      else       kc_prev_q <= kc_f;
   end

   assign kc_o      = kc_f;
   assign kd_o      = kd_sq[1];
   assign kc_fall_o = kc_prev_q & ~kc_f;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 10-bit frame shift, ACK check.
// Optional kc debounce via PS2_TX_GLITCH_FILTER_EN (in ps2_line_sync).
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic         csi_clk,
   input  logic         csi_reset,
   ps2_host_tx_if.slave s1,
   input  logic         coe_kc,
   input  logic         coe_kd,
   output logic         coe_kc_oe,
   output logic         coe_kd_oe
);
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic [3:0]           bitcnt_q;
   logic [7:0]           tx_q, rdata_q;
   logic                 par_q, ie_q, done_q, ackerr_q, tmo_q, ovr_q, irq_q;
   logic                 kc_oe_q, kd_oe_q;
   logic                 kc_s, kd_s, kc_fall;
   logic [FRAME_LEN-1:0] frame;
   logic [7:0]           status;
   logic                 wr_data, wr_ctrl, abort;

   ps2_line_sync u_sync (
      .clk_i     (csi_clk),
      .rst_i     (csi_reset),
      .kc_i      (coe_kc),
      .kd_i      (coe_kd),
      .kc_o      (kc_s),
      .kd_o      (kd_s),
      .kc_fall_o (kc_fall)
   );

   assign frame   = {1'b1, par_q, tx_q};
   assign wr_data = s1.avs_s1_write && (s1.avs_s1_address == ADDR_TXDATA);
   assign wr_ctrl = s1.avs_s1_write && (s1.avs_s1_address == ADDR_CTRL);

   always_comb begin
      status              = '0;
      status[STAT_BUSY]   = (state_q != ST_IDLE);
      status[STAT_DONE]   = done_q;
      status[STAT_ACKERR] = ackerr_q;
      status[STAT_TMO]    = tmo_q;
      status[STAT_OVR]    = ovr_q;
      status[STAT_IE]     = ie_q;
   end

   // A timeout only fires if the awaited event did not arrive in the same cycle.
   always_comb begin
      abort = 1'b0;
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
         unique case (state_q)
            ST_SHIFT, ST_ACK: abort = !kc_fall;
            ST_WAITIDLE:      abort = !(kc_s && kd_s);
            default:          abort = 1'b0;
         endcase
      end
   end

   always_ff @(posedge csi_clk or posedge csi_reset) begin
      if (csi_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         tx_q     <= '0;
         par_q    <= 1'b0;
         rdata_q  <= '0;
         ie_q     <= 1'b0;
         done_q   <= 1'b0;
         ackerr_q <= 1'b0;
         tmo_q    <= 1'b0;
         ovr_q    <= 1'b0;
         irq_q    <= 1'b0;
         kc_oe_q  <= 1'b0;
         kd_oe_q  <= 1'b0;
      end else begin
         irq_q <= ie_q & (done_q | ackerr_q | tmo_q);

         if (s1.avs_s1_read)
            rdata_q <= (s1.avs_s1_address == ADDR_CTRL) ? status : tx_q;

         // Clears come first so any flag set later in this block wins.
         if (wr_ctrl) begin
            ie_q <= s1.avs_s1_writedata[7];
            if (s1.avs_s1_writedata[0]) begin
               done_q   <= 1'b0;
               ackerr_q <= 1'b0;
               tmo_q    <= 1'b0;
               ovr_q    <= 1'b0;
            end
         end

         if (wr_data && state_q != ST_IDLE) ovr_q <= 1'b1;

         unique case (state_q)
            ST_IDLE: begin
               if (wr_data) begin
                  tx_q     <= s1.avs_s1_writedata;
                  par_q    <= ~^s1.avs_s1_writedata;
                  done_q   <= 1'b0;
                  ackerr_q <= 1'b0;
                  tmo_q    <= 1'b0;
                  cnt_q    <= '0;
                  kc_oe_q  <= 1'b1;
                  state_q  <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                  cnt_q   <= '0;
                  kd_oe_q <= 1'b1;
                  state_q <= ST_REQ;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_REQ: begin
               kc_oe_q  <= 1'b0;
               bitcnt_q <= '0;
               cnt_q    <= '0;
               state_q  <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (kc_fall) begin
                  cnt_q   <= '0;
                  kd_oe_q <= ~frame[bitcnt_q];
                  if (bitcnt_q == 4'(FRAME_LEN - 1)) state_q  <= ST_ACK;
                  else                               bitcnt_q <= bitcnt_q + 4'd1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_ACK: begin
               if (kc_fall) begin
                  cnt_q   <= '0;
                  if (kd_s) ackerr_q <= 1'b1;
                  state_q <= ST_WAITIDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_WAITIDLE: begin
               if (kc_s && kd_s) begin
                  if (!ackerr_q) done_q <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (abort) begin
            tmo_q   <= 1'b1;
            kc_oe_q <= 1'b0;
            kd_oe_q <= 1'b0;
            state_q <= ST_IDLE;
         end
      end
   end

   assign coe_kc_oe          = kc_oe_q;
   assign coe_kd_oe          = kd_oe_q;
   assign s1.avs_s1_readdata = rdata_q;
   assign s1.ins_irq0_irq    = irq_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on the open-drain lines.
module tb_ps2_host_tx;
   localparam int INH = 20;
   localparam int TMO = 200;

   logic csi_clk   = 1'b0;
   logic csi_reset = 1'b1;
   logic coe_kc, coe_kd, coe_kc_oe, coe_kd_oe;
   logic dev_kc = 1'b1;
   logic dev_kd = 1'b1;

   int total = 0;
   int bad   = 0;

   ps2_host_tx_if s1_if ();

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .csi_clk   (csi_clk),
      .csi_reset (csi_reset),
      .s1        (s1_if),
      .coe_kc    (coe_kc),
      .coe_kd    (coe_kd),
      .coe_kc_oe (coe_kc_oe),
      .coe_kd_oe (coe_kd_oe)
   );

   always #5 csi_clk = ~csi_clk;

   // Open-drain wired-AND of host and device drivers
   assign coe_kc = dev_kc & ~coe_kc_oe;
   assign coe_kd = dev_kd & ~coe_kd_oe;

   typedef struct {
      logic [7:0] data;
      bit         ack_low;
      logic [9:0] exp_bits;
      logic [7:0] exp_stat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic avs_write(input logic addr, input logic [7:0] data);
      @(negedge csi_clk);
      s1_if.avs_s1_address   = addr;
      s1_if.avs_s1_writedata = data;
      s1_if.avs_s1_write     = 1'b1;
      @(negedge csi_clk);
      s1_if.avs_s1_write     = 1'b0;
   endtask

   task automatic avs_read(input logic addr, output logic [7:0] data);
      @(negedge csi_clk);
      s1_if.avs_s1_address = addr;
      s1_if.avs_s1_read    = 1'b1;
      @(negedge csi_clk);
      s1_if.avs_s1_read    = 1'b0;
      data = s1_if.avs_s1_readdata;
   endtask

   // Device: waits out the inhibit, then issues nfalls clocks, sampling the
   // line at the end of each low phase and optionally pulling data low to ACK.
   task automatic dev_xfer(input int nfalls, input bit ack_low, output logic [9:0] bits,
                           output int kc_low, output bit seen, output logic start);
      int t;
      bits   = '0;
      kc_low = 0;
      t      = 0;
      while (!coe_kc_oe && t < 100) begin
         @(negedge csi_clk);
         t++;
      end
      seen = coe_kc_oe;
      while (coe_kc_oe && kc_low < 1000) begin
         @(negedge csi_clk);
         kc_low++;
      end
      start = coe_kd_oe;
      repeat (8) @(negedge csi_clk);
      for (int i = 0; i < nfalls; i++) begin
         dev_kc = 1'b0;
         repeat (8) @(negedge csi_clk);
         if (i < 10) bits[i] = coe_kd;
         dev_kc = 1'b1;
         if (i == 9 && ack_low) dev_kd = 1'b0;
         repeat (8) @(negedge csi_clk);
         if (i == 10) dev_kd = 1'b1;
      end
   endtask

   vec_t       vecs[3];
   logic [7:0] rd;
   logic [9:0] bits;
   int         kcl;
   bit         seen;
   logic       start;

   initial begin
      vecs[0] = '{data: 8'hED, ack_low: 1'b1, exp_bits: 10'h3ED, exp_stat: 8'h82};
      vecs[1] = '{data: 8'hF4, ack_low: 1'b1, exp_bits: 10'h2F4, exp_stat: 8'h82};
      vecs[2] = '{data: 8'hAA, ack_low: 1'b0, exp_bits: 10'h3AA, exp_stat: 8'h84};

      s1_if.avs_s1_address   = 1'b0;
      s1_if.avs_s1_read      = 1'b0;
      s1_if.avs_s1_write     = 1'b0;
      s1_if.avs_s1_writedata = '0;

      repeat (3) @(negedge csi_clk);
      check("rst_kc_oe", coe_kc_oe, 0);
      check("rst_kd_oe", coe_kd_oe, 0);
      check("rst_irq", s1_if.ins_irq0_irq, 0);
      check("rst_rdata", s1_if.avs_s1_readdata, 0);
      csi_reset = 1'b0;
      avs_read(1'b1, rd);
      check("rst_status", rd, 8'h00);
      avs_read(1'b0, rd);
      check("rst_txdata", rd, 8'h00);

      avs_write(1'b1, 8'h80);

      for (int v = 0; v < 3; v++) begin
         avs_write(1'b0, vecs[v].data);
         dev_xfer(11, vecs[v].ack_low, bits, kcl, seen, start);
         check("kc_oe_seen", seen, 1);
         check("inhibit_len", kcl, INH + 1);
         check("start_bit", start, 1);
         check("frame_bits", bits, vecs[v].exp_bits);
         repeat (4) @(negedge csi_clk);
         avs_read(1'b1, rd);
         check("xfer_status", rd, vecs[v].exp_stat);
         check("xfer_irq", s1_if.ins_irq0_irq, 1);
         avs_read(1'b0, rd);
         check("xfer_txdata", rd, vecs[v].data);
      end

      // Flag clear: irq follows one cycle later
      avs_write(1'b1, 8'h81);
      check("clr_irq_lag", s1_if.ins_irq0_irq, 1);
      @(negedge csi_clk);
      check("clr_irq_drop", s1_if.ins_irq0_irq, 0);
      avs_read(1'b1, rd);
      check("clr_status", rd, 8'h80);

      // Overrun while busy
      avs_write(1'b0, 8'h3C);
      fork
         dev_xfer(11, 1'b1, bits, kcl, seen, start);
         begin
            repeat (5) @(negedge csi_clk);
            avs_write(1'b0, 8'h55);
            avs_read(1'b0, rd);
            check("ovr_txdata", rd, 8'h3C);
            avs_read(1'b1, rd);
            check("ovr_busy_status", rd, 8'h91);
         end
      join
      check("ovr_inhibit_len", kcl, INH + 1);
      check("ovr_frame_bits", bits, 10'h33C);
      repeat (4) @(negedge csi_clk);
      avs_read(1'b1, rd);
      check("ovr_status", rd, 8'h92);
      avs_write(1'b1, 8'h81);

      // Device stops clocking after 4 falls
      avs_write(1'b0, 8'h00);
      dev_xfer(4, 1'b0, bits, kcl, seen, start);
      check("tmo_inhibit_len", kcl, INH + 1);
      check("tmo_kd_driven", coe_kd_oe, 1);
      repeat (150) @(negedge csi_clk);
      avs_read(1'b1, rd);
      check("tmo_still_busy", rd, 8'h81);
      for (int k = 0; k < 120 && !s1_if.ins_irq0_irq; k++) @(negedge csi_clk);
      check("tmo_irq", s1_if.ins_irq0_irq, 1);
      check("tmo_kc_oe", coe_kc_oe, 0);
      check("tmo_kd_oe", coe_kd_oe, 0);
      avs_read(1'b1, rd);
      check("tmo_status", rd, 8'h88);

      // Async reset in SHIFT
      avs_write(1'b0, 8'h00);
      repeat (30) @(negedge csi_clk);
      avs_read(1'b1, rd);
      check("shift_status", rd, 8'h81);
      check("shift_kd_oe", coe_kd_oe, 1);
      #2 csi_reset = 1'b1;
      #1;
      check("arst_kc_oe", coe_kc_oe, 0);
      check("arst_kd_oe", coe_kd_oe, 0);
      @(negedge csi_clk);
      csi_reset = 1'b0;
      avs_read(1'b1, rd);
      check("arst_status", rd, 8'h00);
      check("arst_irq", s1_if.ins_irq0_irq, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
